linebuffer_3x3_stream: RTL and testbench
========================================

Name: linebuffer_3x3_stream

Overview:
Parametrised successor to the fixed-tap 3x3 line buffer. It takes a raster pixel stream with a valid handshake and emits 3x3 windows with a window-valid strobe. Line length and frame height are programmed at runtime in any value up to MAX_W, instead of a fixed set of tap lengths. It adds stride-1/stride-2 window decimation, frame tracking and stall tolerance, and feeds the conv/maxpool PE array in the YOLOv3-Tiny datapath.

Parameters:
DATA_W, 8, pixel width in bits
MAX_W, 256, maximum line length (RAM depth per line)
W_BITS, 9, width of column count/config (must hold MAX_W)
H_BITS, 9, width of row count/config

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  one-cycle strobe; captures cfg_* (honoured only in IDLE)
cfg_width  in  W_BITS  pixels per line, legal range 3..MAX_W
cfg_height  in  H_BITS  lines per frame, legal range 3..2^H_BITS-1
cfg_stride  in  1  0 = stride 1, 1 = stride 2
in_valid  in  1  input pixel valid
in_data  in  DATA_W  input pixel, raster order
in_ready  out  1  1 in RUN, 0 otherwise
win_valid  out  1  one-cycle window strobe
win_data  out  9*DATA_W  window; slice k = 3*i+j holds row r-2+i, col c-2+j
win_row  out  H_BITS  row r of the newest pixel in the emitted window
win_col  out  W_BITS  column c of the newest pixel in the emitted window
frame_done  out  1  one-cycle pulse after the last pixel of a frame
cfg_err  out  1  one-cycle pulse on a rejected cfg_load
busy  out  1  1 in RUN

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs 0, all counters 0, window registers 0. Line RAM contents are not cleared and are don't-care.
- States: IDLE, RUN.
  - IDLE -> RUN on cfg_load with a legal width and height; config is latched the same cycle.
  - An illegal cfg_load (width <3, width >MAX_W, or height <3) pulses cfg_err the next cycle and the block stays in IDLE.
  - cfg_load in RUN is ignored: no cfg_err, no config change.
- Accept: a pixel is accepted when in_valid && in_ready. Nothing shifts or advances without an accept, so stalls are transparent.
- Counters: col wraps from width-1 to 0 and increments row. The accept of (height-1, width-1) returns the block to IDLE; frame_done pulses the following cycle.
- Line storage: two RAMs (MAX_W x DATA_W). LA holds row r-1 and LB holds row r-2, both addressed by col.
  - On accept at col c: read LA[c] and LB[c], then write LB[c] <= old LA[c] and LA[c] <= in_data (read-before-write, same cycle).
- Window: three 3-deep column shift registers load {LB[c], LA[c], in_data} on each accept.
- Window valid: win_valid=1 in the cycle after accepting (r,c) when:
  - r>=2 and c>=2, and
  - for stride 2, additionally (r-2) and (c-2) are both even.
  - win_data, win_row and win_col update in that same cycle and hold until the next window.
  - Latency is 1 cycle from accept. There is no downstream backpressure; the consumer must take every strobe.
- Line boundaries: windows are never emitted for c<2, so no window straddles a line wrap. Rows 0 and 1 of the current frame always overwrite stale RAM data before their use.
- Last pixel: win_valid (if eligible) and frame_done assert in the same cycle.
- Reset mid-frame: the frame is abandoned immediately. No frame_done is issued, and the next frame needs a new cfg_load.
- Window counts per frame:
  - Stride 1: (W-2)*(H-2).
  - Stride 2: ceil((W-2)/2)*ceil((H-2)/2).

Test Plan:
- Stride-1 ramp: cfg W=4, H=4, stride=0; pixels 0..15 with in_valid held high -> 4 windows. First window is 1 cycle after pixel 10 with slices {0,1,2,4,5,6,8,9,10}, win_row=2, win_col=2. Last window is {5,6,7,9,10,11,13,14,15}, and frame_done coincides with it.
- Stride 2: W=6, H=6, ramp 0..35 -> exactly 4 windows, at (r,c) = (2,2), (2,4), (4,2), (4,4). The (4,4) window is {14,15,16,20,21,22,26,27,28}.
- Stall: repeat the stride-1 ramp with in_valid toggling 1,0,0,1,... -> identical window contents and order. win_valid never asserts in a cycle following a non-accept.
- Runtime width change: frame with W=4, H=3 (ramp), then cfg_load W=8, H=3 -> 2 windows, then 6 windows. The first W=8 window is {0,1,2,8,9,10,16,17,18} with no stale data.
- Config checks:
  - cfg_load with W=2 -> cfg_err pulse, busy stays 0, in_ready stays 0.
  - cfg_load during RUN -> ignored, no cfg_err.
- Reset mid-frame: assert rst_n=0 after pixel 7 of a W=4, H=4 frame -> all outputs 0 with no frame_done. Re-run the full frame and check it matches the stride-1 ramp results.

Source files
------------

// File: rtl/linebuffer_3x3_stream.sv
// -----------------------------------------------------------------------------
// linebuffer_3x3_stream
//
// Purpose:
//   Turns a raster pixel stream into 3x3 windows for the conv/maxpool PE
//   array. Line length and frame height are programmed at runtime (up to
//   MAX_W columns). Windows can be emitted at every position (stride 1) or
//   at every other row and column (stride 2). Input stalls are transparent:
//   nothing in the datapath moves unless a pixel is accepted.
//
// Handshake:
//   A pixel is transferred on a rising edge where in_valid && in_ready.
//   in_ready is high only while a frame is running. The window side has no
//   backpressure: win_valid is a one-cycle strobe that the consumer must
//   take, and win_data/win_row/win_col hold their value until the next one.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   cfg_load       one-cycle strobe, captures cfg_* when idle
//   cfg_width      pixels per line, legal 3..MAX_W
//   cfg_height     lines per frame, legal 3..2^H_BITS-1
//   cfg_stride     0 = stride 1, 1 = stride 2
//   in_valid       input pixel valid
//   in_data        input pixel, raster order
//   in_ready       high while a frame is running
//   win_valid      one-cycle window strobe
//   win_data       window, slice k = 3*i+j holds row r-2+i, column c-2+j
//   win_row        row r of the newest pixel in the window
//   win_col        column c of the newest pixel in the window
//   frame_done     one-cycle pulse after the last pixel of a frame
//   cfg_err        one-cycle pulse after a rejected cfg_load
//   busy           high while a frame is running
// -----------------------------------------------------------------------------
module linebuffer_3x3_stream #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 256,
  parameter int W_BITS = 9,
  parameter int H_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_load,
  input  logic [W_BITS-1:0]     cfg_width,
  input  logic [H_BITS-1:0]     cfg_height,
  input  logic                  cfg_stride,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_data,
  output logic [H_BITS-1:0]     win_row,
  output logic [W_BITS-1:0]     win_col,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic                  busy
);

  // Line RAM address width; W_BITS is wider because it must also hold MAX_W.
  localparam int ADDR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state;

  // Latched frame configuration
  logic [W_BITS-1:0]   width_q;
  logic [H_BITS-1:0]   height_q;
  logic                stride_q;

  // Raster position of the next pixel to be accepted
  logic [W_BITS-1:0]   col_q;
  logic [H_BITS-1:0]   row_q;

  // Line RAMs: la holds row r-1, lb holds row r-2, both indexed by column
  logic [DATA_W-1:0]   la_mem [MAX_W];
  logic [DATA_W-1:0]   lb_mem [MAX_W];

  // Column shift registers, tap_q[i][0] is the oldest column, [2] the newest.
  // Row i = 0 carries row r-2, i = 1 row r-1, i = 2 row r.
  logic [DATA_W-1:0]   tap_q [3][3];

  logic                accept;
  logic                cfg_legal;
  logic                col_last;
  logic                row_last;
  logic                eligible;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;
  logic [DATA_W-1:0]   col_in [3];
  logic [9*DATA_W-1:0] win_next;

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign accept   = in_valid && (state == S_RUN);

  assign cfg_legal = (cfg_width  >= W_BITS'(3)) &&
                     (cfg_width  <= W_BITS'(MAX_W)) &&
                     (cfg_height >= H_BITS'(3));

  assign col_last = (col_q == width_q  - W_BITS'(1));
  assign row_last = (row_q == height_q - H_BITS'(1));

  // Stride 2 keeps windows whose (r-2) and (c-2) are even, i.e. even r and c.
  assign eligible = (row_q >= H_BITS'(2)) && (col_q >= W_BITS'(2)) &&
                    (!stride_q || (!row_q[0] && !col_q[0]));

  // Read-before-write: the old contents at this column are read here and the
  // update is written on the same edge that accepts the pixel.
  assign addr = col_q[ADDR_W-1:0];
  assign rd_a = la_mem[addr];
  assign rd_b = lb_mem[addr];

  // Newest column entering the window: {row r-2, row r-1, row r}
  always_comb begin
    col_in[0] = rd_b;
    col_in[1] = rd_a;
    col_in[2] = in_data;
  end

  // Window as it will look after this accept: the two newest stored columns
  // shift left by one and the incoming column lands in position j = 2.
  always_comb begin
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      win_next[(3*i+0)*DATA_W +: DATA_W] = tap_q[i][1];
      win_next[(3*i+1)*DATA_W +: DATA_W] = tap_q[i][2];
      win_next[(3*i+2)*DATA_W +: DATA_W] = col_in[i];
    end
  end

  // Line RAM update. Contents are never reset: rows 0 and 1 of every frame
  // overwrite a column before any window can read it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[addr] <= rd_a;
      la_mem[addr] <= in_data;
    end
  end

  // Control FSM, counters, window taps and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          tap_q[i][j] <= '0;
        end
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            if (cfg_legal) begin
              width_q  <= cfg_width;
              height_q <= cfg_height;
              stride_q <= cfg_stride;
              col_q    <= '0;
              row_q    <= '0;
              state    <= S_RUN;
            end else begin
              cfg_err  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // cfg_load is deliberately ignored while a frame is running.
          if (accept) begin
            for (int i = 0; i < 3; i++) begin
              tap_q[i][0] <= tap_q[i][1];
              tap_q[i][1] <= tap_q[i][2];
              tap_q[i][2] <= col_in[i];
            end

            if (eligible) begin
              win_valid <= 1'b1;
              win_data  <= win_next;
              win_row   <= row_q;
              win_col   <= col_q;
            end

            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q      <= '0;
                frame_done <= 1'b1;
                state      <= S_IDLE;
              end else begin
                row_q <= row_q + H_BITS'(1);
              end
            end else begin
              col_q <= col_q + W_BITS'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linebuffer_3x3_stream.sv
// -----------------------------------------------------------------------------
// tb_linebuffer_3x3_stream
//
// Bench for linebuffer_3x3_stream. Each frame is generated as a flat array of
// pixels; the expected windows are enumerated straight from that image
// (every eligible (r,c), nine pixels by index arithmetic) into exp_q before
// the pixels are streamed in. A negedge monitor pops exp_q on every window
// strobe and checks frame_done placement.
// -----------------------------------------------------------------------------
module tb_linebuffer_3x3_stream;

  localparam int DW = 8;
  localparam int MW = 256;
  localparam int WB = 9;
  localparam int HB = 9;
  localparam int EW = 9*DW + WB + HB;

  // ---------------------------------------------------------------- clock/reset
  logic            clk;
  logic            rst_n;
  logic            cfg_load;
  logic [WB-1:0]   cfg_width;
  logic [HB-1:0]   cfg_height;
  logic            cfg_stride;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            win_valid;
  logic [9*DW-1:0] win_data;
  logic [HB-1:0]   win_row;
  logic [WB-1:0]   win_col;
  logic            frame_done;
  logic            cfg_err;
  logic            busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  linebuffer_3x3_stream #(
    .DATA_W (DW),
    .MAX_W  (MW),
    .W_BITS (WB),
    .H_BITS (HB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_stride (cfg_stride),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  int              checks   = 0;
  int              failures = 0;
  logic [EW-1:0]   exp_q[$];
  int              pix [4096];
  bit              exp_last_win;
  int              win_cnt;
  int              fd_cnt;
  int              err_cnt;
  logic [9*DW-1:0] last_win;
  bit              last_acc;

  task automatic chk(input string tag, input logic [EW-1:0] obs,
                     input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) last_acc <= in_valid && in_ready && rst_n;

  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        win_cnt++;
        last_win = win_data;
        chk("win_follows_accept", EW'(last_acc), EW'(1));
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL win_unexpected observed=row%0d_col%0d expected=no_window",
                 win_row, win_col);
        end
        if (exp_q.size() > 0)
          chk("win", {win_row, win_col, win_data}, exp_q.pop_front());
      end
      if (frame_done) begin
        fd_cnt++;
        chk("last_win_with_done", EW'(win_valid), EW'(exp_last_win));
      end
      if (cfg_err) err_cnt++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic start_frame(input int w, input int h, input bit s, input bit ramp);
    logic [9*DW-1:0] d;
    exp_q.delete();
    win_cnt = 0;
    fd_cnt  = 0;
    err_cnt = 0;
    for (int idx = 0; idx < w*h; idx++)
      pix[idx] = ramp ? (idx % 256) : int'($urandom_range(0, 255));
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        if (!s || (((r-2) % 2 == 0) && ((c-2) % 2 == 0))) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              d[(3*i+j)*DW +: DW] = DW'(pix[(r-2+i)*w + (c-2+j)]);
          exp_q.push_back({HB'(r), WB'(c), d});
        end
      end
    end
    exp_last_win = !s || ((((h-3) % 2) == 0) && (((w-3) % 2) == 0));
    @(negedge clk);
    cfg_load   = 1'b1;
    cfg_width  = WB'(w);
    cfg_height = HB'(h);
    cfg_stride = s;
    @(negedge clk);
    cfg_load   = 1'b0;
    chk("cfg_busy", EW'(busy), EW'(1));
    chk("cfg_ready", EW'(in_ready), EW'(1));
  endtask

  // stall: 0 = valid held high, 1 = valid pattern 1,0,0, 2 = random
  // mid_cfg: pixel index at which a cfg_load is raised during the frame
  task automatic feed(input int first, input int last, input int stall,
                      input int mid_cfg);
    int cyc;
    bit v;
    cyc = 0;
    for (int idx = first; idx < last; idx++) begin
      do begin
        v = (stall == 0) ? 1'b1 :
            (stall == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 1) == 1);
        in_valid = v;
        in_data  = v ? DW'(pix[idx]) : DW'($urandom);
        if (idx == mid_cfg && v) begin
          cfg_load   = 1'b1;
          cfg_width  = WB'(3);
          cfg_height = HB'(5);
          cfg_stride = 1'b1;
        end else begin
          cfg_load = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end while (!v);
    end
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic end_frame(input int w, input int h, input bit s);
    int n;
    int guard;
    n = s ? ((w-1)/2) * ((h-1)/2) : (w-2) * (h-2);
    guard = 0;
    while (fd_cnt == 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("frame_done_cnt", EW'(fd_cnt), EW'(1));
    chk("win_cnt", EW'(win_cnt), EW'(n));
    chk("exp_q_empty", EW'(exp_q.size()), EW'(0));
    chk("idle_busy", EW'(busy), EW'(0));
    chk("idle_ready", EW'(in_ready), EW'(0));
    chk("no_cfg_err", EW'(err_cnt), EW'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_win_valid"}, EW'(win_valid), EW'(0));
    chk({tag, "_win_data"}, EW'(win_data), EW'(0));
    chk({tag, "_win_row"}, EW'(win_row), EW'(0));
    chk({tag, "_win_col"}, EW'(win_col), EW'(0));
    chk({tag, "_frame_done"}, EW'(frame_done), EW'(0));
    chk({tag, "_cfg_err"}, EW'(cfg_err), EW'(0));
    chk({tag, "_busy"}, EW'(busy), EW'(0));
    chk({tag, "_in_ready"}, EW'(in_ready), EW'(0));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------------------------------------------------------- stimulus
  int bad_w [3] = '{2, 257, 5};
  int bad_h [3] = '{4, 4, 2};
  logic [9*DW-1:0] s2_exp;
  int s2_vals [9] = '{14, 15, 16, 20, 21, 22, 26, 27, 28};

  initial begin
    rst_n      = 1'b0;
    cfg_load   = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_stride = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    win_cnt    = 0;
    fd_cnt     = 0;
    err_cnt    = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", EW'(busy), EW'(0));

    // Stride-1 ramp, W=4 H=4
    start_frame(4, 4, 1'b0, 1'b1);
    feed(0, 16, 0, -1);
    end_frame(4, 4, 1'b0);

    // Stride-2 ramp, W=6 H=6; last window is the (4,4) one
    start_frame(6, 6, 1'b1, 1'b1);
    feed(0, 36, 0, -1);
    end_frame(6, 6, 1'b1);
    for (int k = 0; k < 9; k++) s2_exp[k*DW +: DW] = DW'(s2_vals[k]);
    chk("s2_win_4_4", EW'(last_win), EW'(s2_exp));

    // Stride-1 ramp with valid toggling 1,0,0
    start_frame(4, 4, 1'b0, 1'b1);
    feed(0, 16, 1, -1);
    end_frame(4, 4, 1'b0);

    // Runtime width change: W=4 H=3, then W=8 H=3
    start_frame(4, 3, 1'b0, 1'b1);
    feed(0, 12, 0, -1);
    end_frame(4, 3, 1'b0);
    start_frame(8, 3, 1'b0, 1'b1);
    feed(0, 24, 0, -1);
    end_frame(8, 3, 1'b0);

    // Illegal configurations are rejected with a one-cycle cfg_err
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      cfg_load   = 1'b1;
      cfg_width  = WB'(bad_w[t]);
      cfg_height = HB'(bad_h[t]);
      cfg_stride = 1'b0;
      @(negedge clk);
      cfg_load = 1'b0;
      chk("bad_cfg_err", EW'(cfg_err), EW'(1));
      chk("bad_cfg_busy", EW'(busy), EW'(0));
      chk("bad_cfg_ready", EW'(in_ready), EW'(0));
      @(negedge clk);
      chk("bad_cfg_err_pulse", EW'(cfg_err), EW'(0));
      chk("bad_cfg_still_idle", EW'(busy), EW'(0));
    end

    // cfg_load during a frame is ignored
    start_frame(5, 5, 1'b0, 1'b0);
    feed(0, 25, 2, 7);
    end_frame(5, 5, 1'b0);

    // Reset mid-frame after pixel 7, then the full frame again
    start_frame(4, 4, 1'b0, 1'b1);
    feed(0, 8, 0, -1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("after_reset");
    chk("mid_reset_no_done", EW'(fd_cnt), EW'(0));
    start_frame(4, 4, 1'b0, 1'b1);
    feed(0, 16, 0, -1);
    end_frame(4, 4, 1'b0);

    // Full-width lines with random data and random stalls
    start_frame(MW, 3, 1'b0, 1'b0);
    feed(0, MW*3, 2, -1);
    end_frame(MW, 3, 1'b0);
    start_frame(MW, 4, 1'b1, 1'b0);
    feed(0, MW*4, 2, -1);
    end_frame(MW, 4, 1'b1);

    // Random geometry, stride and stall pattern
    for (int f = 0; f < 8; f++) begin
      int w;
      int h;
      bit s;
      int st;
      w  = int'($urandom_range(3, 24));
      h  = int'($urandom_range(3, 12));
      s  = bit'($urandom_range(0, 1));
      st = int'($urandom_range(0, 2));
      start_frame(w, h, s, 1'b0);
      feed(0, w*h, st, -1);
      end_frame(w, h, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
